// File: rtl/sub_arbiter_if.sv
// Handshake bundle between the two subtract requesters, the shared subtractor and its consumer.
// Requesters and consumer use the master view; the arbiter uses the slave view.
interface sub_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_r;
    logic             rsp_zero;
    logic             rsp_neg;
    logic             rsp_ovf;
    logic             rsp_borrow;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_neg, rsp_ovf, rsp_borrow
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_neg, rsp_ovf, rsp_borrow
    );
endinterface

// File: rtl/sub_arbiter.sv
// Shared signed subtractor for ALU (port 0) and branch compare (port 1); flags built only with SUB_ARB_FLAGS_EN.
// 1-cycle latency into a single-entry buffer; readies drop while the buffer is full and not being drained.
module sub_arbiter #(
    parameter int WIDTH      = 32,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    sub_arbiter_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_e;

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             id_q;
    logic [WIDTH-1:0] r_q;

    logic             load;
    logic             both;
    logic             gnt1;
    logic             accept;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        load    = (state_q == EMPTY) || bus.rsp_ready;
        both    = bus.req0_valid && bus.req1_valid;
        gnt1    = both ? (PRIO_FIXED ? 1'b0 : ptr_q) : bus.req1_valid;
        accept  = load && (bus.req0_valid || bus.req1_valid);
        a_sel   = gnt1 ? bus.req1_a : bus.req0_a;
        b_sel   = gnt1 ? bus.req1_b : bus.req0_b;
        diff    = a_sel - b_sel;

        bus.req0_ready = load && bus.req0_valid && !gnt1;
        bus.req1_ready = load && bus.req1_valid && gnt1;

        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (bus.rsp_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase

        // Pointer moves only when both contended, so the loser wins next time.
        if (accept && both) ptr_d = !gnt1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q <= 1'b0;
            r_q  <= '0;
        end else if (accept) begin
            id_q <= gnt1;
            r_q  <= diff;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_r     = r_q;

`ifdef SUB_ARB_FLAGS_EN
    logic zero_q, neg_q, ovf_q, borrow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else if (accept) begin
            zero_q   <= (diff == '0);
            neg_q    <= diff[WIDTH-1];
            ovf_q    <= (a_sel[WIDTH-1] != b_sel[WIDTH-1]) && (diff[WIDTH-1] != a_sel[WIDTH-1]);
            borrow_q <= (a_sel < b_sel);
        end
    end

    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_neg    = neg_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.rsp_borrow = borrow_q;
`else
    assign bus.rsp_zero   = 1'b0;
    assign bus.rsp_neg    = 1'b0;
    assign bus.rsp_ovf    = 1'b0;
    assign bus.rsp_borrow = 1'b0;
`endif
endmodule

// File: tb/tb_sub_arbiter.sv
// Directed bench for sub_arbiter: round-robin instance plus a fixed-priority instance.
module tb_sub_arbiter;
`ifdef SUB_ARB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sub_arbiter_if #(.WIDTH(32)) bus ();
    sub_arbiter_if #(.WIDTH(32)) bus_f ();

    sub_arbiter #(.WIDTH(32), .PRIO_FIXED(1'b0)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sub_arbiter #(.WIDTH(32), .PRIO_FIXED(1'b1)) dut_fx (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [31:0] r,
                             input logic z, input logic n, input logic o, input logic b);
        check({tag, " valid"},  {31'd0, bus.rsp_valid}, 32'd1);
        check({tag, " id"},     {31'd0, bus.rsp_id},    {31'd0, id});
        check({tag, " r"},      bus.rsp_r,              r);
        check({tag, " zero"},   {31'd0, bus.rsp_zero},  {31'd0, z && FLAGS});
        check({tag, " neg"},    {31'd0, bus.rsp_neg},   {31'd0, n && FLAGS});
        check({tag, " ovf"},    {31'd0, bus.rsp_ovf},   {31'd0, o && FLAGS});
        check({tag, " borrow"}, {31'd0, bus.rsp_borrow},{31'd0, b && FLAGS});
    endtask

    // One uncontended request on a single port, then check the buffered result.
    task automatic single(input string tag, input logic port, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input logic z, input logic n, input logic o, input logic bw);
        @(posedge clk); #1;
        if (port) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        @(negedge clk);
        check({tag, " rdy0"}, {31'd0, bus.req0_ready}, {31'd0, !port});
        check({tag, " rdy1"}, {31'd0, bus.req1_ready}, {31'd0, port});
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check_rsp(tag, port, r, z, n, o, bw);
    endtask

    initial begin
        logic        g;
        logic [31:0] a0, b0, a1, b1, exp_r;
        n_checks = 0;
        n_errors = 0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b1;
        bus_f.req0_valid = 1'b0; bus_f.req0_a = '0; bus_f.req0_b = '0;
        bus_f.req1_valid = 1'b0; bus_f.req1_a = '0; bus_f.req1_b = '0;
        bus_f.rsp_ready  = 1'b1;
        rst_n = 1'b0;

        // Reset state
        #12;
        check("rst valid",  {31'd0, bus.rsp_valid},  32'd0);
        check("rst id",     {31'd0, bus.rsp_id},     32'd0);
        check("rst r",      bus.rsp_r,               32'd0);
        check("rst flags",  {28'd0, bus.rsp_zero, bus.rsp_neg, bus.rsp_ovf, bus.rsp_borrow}, 32'd0);
        check("rst rdy",    {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Uncontended vectors
        single("p0 40-21",  1'b0, 32'd40, 32'd21, 32'd19,         1'b0, 1'b0, 1'b0, 1'b0);
        single("p0 20-40",  1'b0, 32'd20, 32'd40, 32'hFFFF_FFEC,  1'b0, 1'b1, 1'b0, 1'b1);
        single("p1 20-20",  1'b1, 32'd20, 32'd20, 32'd0,          1'b1, 1'b0, 1'b0, 1'b0);
        single("p1 neg-20", 1'b1, 32'hFFFF_FFE7, 32'd20, 32'hFFFF_FFD3, 1'b0, 1'b1, 1'b0, 1'b0);
        single("p1 min-1",  1'b1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1, 1'b0);

        // Round-robin contention: accepted port presents fresh operands after each accept
        @(posedge clk); #1;
        a0 = 32'd100; b0 = 32'd1; a1 = 32'd200; b1 = 32'd3;
        bus.req0_valid = 1'b1; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = 1'b1; bus.req1_a = a1; bus.req1_b = b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            g = (i % 2) != 0;
            check($sformatf("rr%0d rdy0", i), {31'd0, bus.req0_ready}, {31'd0, !g});
            check($sformatf("rr%0d rdy1", i), {31'd0, bus.req1_ready}, {31'd0, g});
            exp_r = g ? (a1 - b1) : (a0 - b0);
            @(posedge clk); #1;
            if (g) begin a1 = a1 + 32'd7; bus.req1_a = a1; end
            else   begin a0 = a0 + 32'd5; bus.req0_a = a0; end
            @(negedge clk);
            check($sformatf("rr%0d id", i), {31'd0, bus.rsp_id}, {31'd0, g});
            check($sformatf("rr%0d r", i),  bus.rsp_r, exp_r);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Backpressure: buffered 40-21 must hold while both ports wait
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd40; bus.req0_b = 32'd21;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        bus.req0_a = 32'd7; bus.req0_b = 32'd2;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd9; bus.req1_b = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp%0d r", i),   bus.rsp_r, 32'd19);
            check($sformatf("bp%0d rdy", i), {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("drain rdy0", {31'd0, bus.req0_ready}, 32'd1);
        check("drain rdy1", {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(negedge clk);
        check("drain new id", {31'd0, bus.rsp_id}, 32'd0);
        check("drain new r",  bus.rsp_r, 32'd5);
        check("p1 next rdy",  {31'd0, bus.req1_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("p1 after id", {31'd0, bus.rsp_id}, 32'd1);
        check("p1 after r",  bus.rsp_r, 32'd5);

        // Async reset while full; pointer currently favours port 1
        #2;
        rst_n = 1'b0;
        #1;
        check("arst valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("arst r",     bus.rsp_r, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd50; bus.req0_b = 32'd8;
        bus.req1_valid = 1'b1; bus.req1_a = 32'd60; bus.req1_b = 32'd9;
        @(negedge clk);
        check("post rst rdy0", {31'd0, bus.req0_ready}, 32'd1);
        check("post rst rdy1", {31'd0, bus.req1_ready}, 32'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check("post rst id", {31'd0, bus.rsp_id}, 32'd0);
        check("post rst r",  bus.rsp_r, 32'd42);

        // Fixed priority: port 0 always wins
        @(posedge clk); #1;
        bus_f.req0_valid = 1'b1; bus_f.req0_a = 32'd30; bus_f.req0_b = 32'd10;
        bus_f.req1_valid = 1'b1; bus_f.req1_a = 32'd90; bus_f.req1_b = 32'd10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("fx%0d rdy1", i), {31'd0, bus_f.req1_ready}, 32'd0);
            check($sformatf("fx%0d rdy0", i), {31'd0, bus_f.req0_ready}, 32'd1);
            @(posedge clk); #1;
            bus_f.req0_a = bus_f.req0_a + 32'd1;
            @(negedge clk);
            check($sformatf("fx%0d id", i), {31'd0, bus_f.rsp_id}, 32'd0);
            check($sformatf("fx%0d r", i),  bus_f.rsp_r, 32'd20 + i);
        end
        bus_f.req0_valid = 1'b0;
        bus_f.req1_valid = 1'b0;

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sub_arbiter.md
Name: sub_arbiter

Overview:
- Shares one WIDTH-bit signed subtractor between two requesters: port 0 is the ALU execute stage (SUB/SLT); port 1 is the branch compare unit (BEQ/BLT).
- Arbitrates per cycle with a valid/ready handshake and registers the difference plus requester ID in a single-entry output buffer.
- The buffer holds its contents under backpressure.
- Sits between the ID/EX operand muxes and the EX result and branch-decision logic.

Parameters:
WIDTH, 32, operand and result width in bits
PRIO_FIXED, 0, 0 = round-robin between ports; 1 = port 0 always wins contention

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  port 0 has operands
req0_ready  out  1  port 0 operands accepted this cycle
req0_a  in  WIDTH  port 0 minuend
req0_b  in  WIDTH  port 0 subtrahend
req1_valid  in  1  port 1 has operands
req1_ready  out  1  port 1 operands accepted this cycle
req1_a  in  WIDTH  port 1 minuend
req1_b  in  WIDTH  port 1 subtrahend
rsp_valid  out  1  output buffer holds a result
rsp_ready  in  1  consumer takes the result
rsp_id  out  1  requester that produced the result
rsp_r  out  WIDTH  A - B
rsp_zero  out  1  result == 0
rsp_neg  out  1  result MSB
rsp_ovf  out  1  signed overflow
rsp_borrow  out  1  unsigned A < B

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_r=0, all flags 0, round-robin pointer favours port 0. Reset mid-operation discards the buffered result with no response emitted.
- Arithmetic: rsp_r = (A - B) mod 2^WIDTH, two's complement, no saturation.
- Load enable: load = !rsp_valid || rsp_ready. This allows a new accept in the same cycle the buffer drains.
- Grant (combinational):
  - Only one port valid: that port is granted.
  - Both valid, PRIO_FIXED=1: port 0 is granted.
  - Both valid, PRIO_FIXED=0: the port indicated by the pointer is granted.
- reqN_ready = load && grant==N. The non-granted ready is 0. A ready never asserts for a port whose valid is 0.
- Handshakes:
  - Accept is valid && ready. On accept, the buffer loads the difference and the ID, and rsp_valid=1 on the next cycle. Latency is 1 cycle.
  - rsp_valid && rsp_ready with no new accept: rsp_valid falls next cycle.
  - rsp_valid && !rsp_ready: rsp_r, rsp_id and the flags hold stable; both readies are 0.
  - Requesters must hold valid and operands until accepted.
- Pointer: updates only on a contended accept (both valid), pointing to the non-granted port. An uncontended accept leaves the pointer unchanged.
- Throughput: one result per cycle with rsp_ready tied high. Under continuous contention with PRIO_FIXED=0, grants alternate 0,1,0,1.
- State:
  - EMPTY (rsp_valid=0): goes to FULL on accept.
  - FULL (rsp_valid=1):
    - rsp_ready with accept: stays FULL with new data.
    - rsp_ready without accept: goes to EMPTY.
    - !rsp_ready: stays FULL.

Optional Feature:
- Macro: SUB_ARB_FLAGS_EN
- Defined:
  - Flags are registered alongside rsp_r from the same operands.
  - zero = (R==0).
  - neg = R[WIDTH-1].
  - ovf = (A[MSB]!=B[MSB]) && (R[MSB]!=A[MSB]).
  - borrow = A<B unsigned.
- Undefined: the four flag ports still exist, tied to 0; no flag logic is synthesized.

Test Plan:
- Port 0 alone:
  - A=40, B=21: next cycle rsp_valid=1, rsp_id=0, rsp_r=19, all flags 0.
  - A=20, B=40: rsp_r=0xFFFFFFEC, neg=1, borrow=1, zero=0.
- Port 1 alone:
  - A=20, B=20: rsp_id=1, rsp_r=0, zero=1.
  - A=0xFFFFFFE7, B=20: rsp_r=0xFFFFFFD3, neg=1, borrow=0.
  - A=0x80000000, B=1: rsp_r=0x7FFFFFFF, ovf=1, neg=0.
- Contention (PRIO_FIXED=0, rsp_ready=1): both valid for 4 cycles with distinct operands. Required: accepts go 0,1,0,1; rsp_id sequence 0,1,0,1; each rsp_r matches its operands.
- Contention (PRIO_FIXED=1): port 0 held valid continuously. Required: req1_ready stays 0 and every rsp_id=0.
- Backpressure: accept 40-21, then rsp_ready=0 for 3 cycles with both ports valid. Required: rsp_r holds 19, both readies stay 0. Raise rsp_ready: the buffered result drains and a new accept occurs in the same cycle.
- Reset: assert rst_n=0 asynchronously while rsp_valid=1. Required: rsp_valid=0 immediately; after release, first contention grants port 0. Build without SUB_ARB_FLAGS_EN: flag ports always 0 for the 20-40 case.
